imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side partner of the instruction memory that the 16-bit processor reads through its 3-bit pc.
- Receives a program as a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words from it.
- Writes those words into the instruction memory and holds the processor in reset until a load completes and its checksum verifies.

Parameters:
- ADDR_W, 3, instruction-memory address width; depth = 2**ADDR_W words (matches the 3-bit pc).
- DATA_W, 16, instruction width; fixed at 2 bytes per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts the byte this cycle; transfer occurs when byte_valid && byte_ready.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- cpu_rst  out  1  holds the processor in reset; drives the processor's rst.
- done  out  1  level; load complete and checksum good.
- error  out  1  level; bad word count or checksum mismatch.

Behaviour:
- Frame format: COUNT byte N, then 2N data bytes (high byte first per word), then CHK byte. CHK = XOR of all 2N data bytes.
- Reset (rst=1 at a clock edge, from any state including mid-load):
  - state=IDLE; byte_ready=0; wr_en=0; wr_addr=0; wr_data=0; done=0; error=0; cpu_rst=1.
  - Internal counters and the checksum accumulator are cleared.
- States and transitions:
  - IDLE: start -> COUNT.
  - COUNT: byte_ready=1. On accept, if 1 <= N <= 2**ADDR_W: latch N, clear words_left/addr/xor, go to HI. Otherwise go to ERR. N is compared as 8-bit unsigned; N=0 and N>depth are both errors.
  - HI: byte_ready=1. On accept: latch the high byte, xor ^= byte, go to LO.
  - LO: byte_ready=1. On accept, the next cycle drives wr_en=1, wr_data={hi,lo}, wr_addr=current addr; xor ^= byte. The address then increments.
    - If the last word was written: -> CHK.
    - Otherwise: -> HI.
  - CHK: byte_ready=1. On accept, if byte == xor -> DONE, else -> ERR.
  - DONE: done=1, cpu_rst=0, byte_ready=0. start -> COUNT; on that transition done clears and cpu_rst reasserts the same cycle.
  - ERR: error=1, cpu_rst=1, byte_ready=0. start -> COUNT and clears error.
- Handshake rules:
  - byte_ready is a registered function of state only. It does not depend on byte_valid in the same cycle.
  - A byte is consumed only on valid && ready. Idle cycles (valid=0) may appear anywhere in a frame with no effect.
- wr_en:
  - Asserted exactly one cycle per word, registered, one cycle after the LO byte is accepted.
  - wr_addr and wr_data are stable during that cycle.
  - Back-to-back words at full rate give one write every 2 cycles.
- Address counter: ADDR_W bits, starts at 0. A separate words_left counter of ADDR_W+1 bits makes N = depth terminate correctly with no wrap aliasing.
- cpu_rst:
  - 1 in every state except DONE.
  - Deasserts the cycle after the CHK accept that enters DONE.
- Partial loads: words already written before an error are not rolled back, but cpu_rst stays high.
- start outside IDLE/DONE/ERR is ignored.
- Simultaneous start and rst: rst wins.
- Latency, N words at full rate: 1 + 2N + 1 accepted bytes. done rises 1 cycle after the CHK accept.

Decomposition:
- Shared package `imem_pkg`:
  - Constants IMEM_ADDR_W=3 and INSTR_W=16.
  - Loader state enum (IDLE, COUNT, HI, LO, CHK, DONE, ERR).
- Sub-module: `byte_pair_assembler`, which holds the high byte, emits the 16-bit word plus a one-cycle word_valid, and accumulates the XOR.
- The FSM, counters and outputs stay in imem_loader.

Test Plan:
- Nominal, N=2, bytes 0x02,0x12,0x34,0xAB,0xCD,CHK=0x12^0x34^0xAB^0xCD=0x40, valid held high -> writes (0,0x1234) then (1,0xABCD); done=1; cpu_rst=0; error=0.
- Full memory, N=8, words 0x0000..0x0007, correct CHK -> 8 writes at addr 0..7, no address wrap, done=1.
- Bad count: COUNT=0x00, then a separate load with COUNT=0x09 -> no wr_en in either case; error=1; cpu_rst=1; byte_ready=0.
- Checksum fail, N=1, 0x01,0xBE,0xEF, CHK=0x00 -> write (0,0xBEEF) occurs; error=1; done=0; cpu_rst stays 1.
- Gapped stream (byte_valid toggling every other cycle) and byte_valid held with byte_ready low in IDLE -> same writes as the nominal case; no byte consumed before start.
- rst asserted after the HI byte of word 1 -> all outputs at reset values next cycle; a subsequent start plus a full frame loads correctly from addr 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 3;
    localparam int unsigned INSTR_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs high/low stream bytes into one instruction word and keeps a running
// XOR of every data byte for the frame checksum.
module byte_pair_assembler #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hi_load,
    input  logic              lo_load,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic [7:0]        xor_acc
);

    logic [DATA_W-9:0] hi_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            xor_acc    <= '0;
        end else begin
            word_valid <= lo_load;
            if (clear) begin
                xor_acc <= '0;
            end
            if (hi_load) begin
                hi_byte <= byte_in;
                xor_acc <= xor_acc ^ byte_in;
            end
            if (lo_load) begin
                word    <= {hi_byte, byte_in};
                xor_acc <= xor_acc ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and holds the processor
// in reset until a complete frame with a good checksum has been written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    loader_state_t     state, next_state;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        xor_acc;
    logic              accept;
    logic              count_load, hi_load, lo_load;

    assign accept = byte_valid && byte_ready;

    byte_pair_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (count_load),
        .hi_load    (hi_load),
        .lo_load    (lo_load),
        .byte_in    (byte_in),
        .word       (wr_data),
        .word_valid (wr_en),
        .xor_acc    (xor_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        count_load = 1'b0;
        hi_load    = 1'b0;
        lo_load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = COUNT;
            end
            COUNT: begin
                if (accept) begin
                    // N is an 8-bit unsigned count; 0 and anything past depth are rejected
                    if (byte_in >= 8'd1 && byte_in <= 8'(DEPTH)) begin
                        count_load = 1'b1;
                        next_state = HI;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
            HI: begin
                if (accept) begin
                    hi_load    = 1'b1;
                    next_state = LO;
                end
            end
            LO: begin
                if (accept) begin
                    lo_load    = 1'b1;
                    next_state = (words_left == (ADDR_W+1)'(1)) ? CHK : HI;
                end
            end
            CHK: begin
                if (accept) begin
                    next_state = (byte_in == xor_acc) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (start) next_state = COUNT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst    <= 1'b1;
            words_left <= '0;
            addr       <= '0;
            wr_addr    <= '0;
        end else begin
            byte_ready <= (next_state == COUNT) || (next_state == HI) ||
                          (next_state == LO)    || (next_state == CHK);
            done       <= (next_state == DONE);
            error      <= (next_state == ERR);
            cpu_rst    <= (next_state != DONE);
            if (count_load) begin
                words_left <= (ADDR_W+1)'(byte_in);
                addr       <= '0;
            end
            if (lo_load) begin
                wr_addr    <= addr;
                addr       <= addr + ADDR_W'(1);
                words_left <= words_left - (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as frames are sent
// and checked against the write port as they appear.
module tb_imem_loader;
    import imem_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   wr_en;
    logic [IMEM_ADDR_W-1:0] wr_addr;
    logic [INSTR_W-1:0]     wr_data;
    logic                   cpu_rst;
    logic                   done;
    logic                   error;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    logic [IMEM_ADDR_W+INSTR_W-1:0] exp_q[$];
    logic [INSTR_W-1:0]             prog [8];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write-port monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [IMEM_ADDR_W+INSTR_W-1:0] e;
            logic [IMEM_ADDR_W+INSTR_W-1:0] got;
            writes++;
            checks++;
            got = {wr_addr, wr_data};
            if (exp_q.size() == 0) begin
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_write observed=%h expected=none", got);
                end
            end else begin
                e = exp_q.pop_front();
                assert (got === e) else begin
                    failures++;
                    $error("FAIL write observed=%h expected=%h", got, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Send a whole frame for prog[0..n-1]; queue the writes it should cause.
    task automatic run_frame(input int n, input bit use_chk, input logic [7:0] chk_val,
                             input bit gap);
        logic [7:0] x;
        x = 8'h00;
        pulse_start();
        send_byte(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({IMEM_ADDR_W'(i), prog[i]});
            x = x ^ prog[i][15:8] ^ prog[i][7:0];
            send_byte(prog[i][15:8], gap);
            check("cpu_rst_mid", 32'(cpu_rst), 32'd1);
            send_byte(prog[i][7:0], gap);
        end
        send_byte(use_chk ? chk_val : x, 1'b0);
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    endtask

    initial begin
        int w0;
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Valid held in IDLE: nothing is accepted before start.
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;

        // Nominal two-word load, CHK = 0x40.
        prog[0] = 16'h1234;
        prog[1] = 16'hABCD;
        w0 = writes;
        run_frame(2, 1'b1, 8'h40, 1'b0);
        check_status("nominal", 1'b1, 1'b0, 1'b0);
        check("nominal_writes", 32'(writes - w0), 32'd2);
        repeat (2) @(negedge clk);

        // Full memory, N = depth.
        for (int i = 0; i < 8; i++) prog[i] = 16'(i);
        w0 = writes;
        run_frame(8, 1'b0, 8'h00, 1'b0);
        check_status("full", 1'b1, 1'b0, 1'b0);
        check("full_writes", 32'(writes - w0), 32'd8);
        repeat (2) @(negedge clk);

        // Bad counts: zero and depth+1.
        w0 = writes;
        pulse_start();
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        check_status("count0", 1'b0, 1'b1, 1'b1);
        pulse_start();
        check("restart_error", 32'(error), 32'd0);
        send_byte(8'h09, 1'b0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_status("count9", 1'b0, 1'b1, 1'b1);
        check("badcount_writes", 32'(writes - w0), 32'd0);

        // Checksum mismatch: the word is still written, CPU stays in reset.
        prog[0] = 16'hBEEF;
        w0 = writes;
        run_frame(1, 1'b1, 8'h00, 1'b0);
        check_status("badchk", 1'b0, 1'b1, 1'b1);
        check("badchk_writes", 32'(writes - w0), 32'd1);
        repeat (2) @(negedge clk);

        // Gapped stream gives the same result as the nominal load.
        prog[0] = 16'h1234;
        prog[1] = 16'hABCD;
        w0 = writes;
        run_frame(2, 1'b1, 8'h40, 1'b1);
        check_status("gapped", 1'b1, 1'b0, 1'b0);
        check("gapped_writes", 32'(writes - w0), 32'd2);

        // Reset in the middle of a frame, then a clean reload from address 0.
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        byte_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        w0 = writes;
        run_frame(2, 1'b1, 8'h40, 1'b0);
        check_status("reload", 1'b1, 1'b0, 1'b0);
        check("reload_writes", 32'(writes - w0), 32'd2);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
